countdown_timer: RTL and testbench

Seconds countdown timer, the down-counting counterpart of the existing up-counting stopwatch. It shares that block's display interface: 0..59 s as BCD, NUM_1S[3:0] and NUM_10S[2:0].
- Preset is loaded from the same BCD format.
- Counts down at 1 Hz, derived from CLK via a CLK_FREQ prescaler, while START is held high.
- Flags expiry with a one-cycle DONE pulse.
- Outputs feed the same 7-segment display path as the stopwatch.

---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/tick_prescaler.sv | 38 +++
 rtl/countdown_timer.sv | 147 ++++++++++++++
 tb/tb_countdown_timer.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared constants and helpers for the stopwatch / countdown timer family.
// Digits are BCD: units 0..9 on W1S bits, tens 0..5 on W10S bits.
package stopwatch_pkg;

  localparam int W1S  = 4;
  localparam int W10S = 3;

  localparam logic [W1S-1:0]  MAX_1S  = 4'd9;
  localparam logic [W10S-1:0] MAX_10S = 3'd5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  function automatic logic [W1S-1:0] clamp_1s(input logic [W1S-1:0] d);
    return (d > MAX_1S) ? MAX_1S : d;
  endfunction

  function automatic logic [W10S-1:0] clamp_10s(input logic [W10S-1:0] d);
    return (d > MAX_10S) ? MAX_10S : d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides CLK down to a one-cycle TICK every CLK_FREQ enabled cycles.
// The count is held while EN is low, so a paused second resumes where it stopped.
module tick_prescaler #(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_r;

  // Enabled cycle counter, wrapping at LAST; CLR takes priority over EN.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt_r <= '0;
    end else if (CLR) begin
      cnt_r <= '0;
    end else if (EN) begin
      if (cnt_r == LAST) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + ONE;
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign TICK = EN && (cnt_r == LAST);

endmodule

// File: rtl/countdown_timer.sv
// Seconds countdown timer (00..59 BCD) with 1 Hz prescaled decrement and DONE pulse.
// Optional periodic reload on expiry when COUNTDOWN_AUTORELOAD_EN is defined.
module countdown_timer
  import stopwatch_pkg::*;
#(
  parameter int CLK_FREQ = 100_000_000
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            LOAD,
  input  logic [W1S-1:0]  LOAD_1S,
  input  logic [W10S-1:0] LOAD_10S,
  input  logic            START,
  output logic [W1S-1:0]  NUM_1S,
  output logic [W10S-1:0] NUM_10S,
  output logic            BUSY,
  output logic            DONE
);

  state_e          state_r;
  logic [W1S-1:0]  num_1s_r;
  logic [W10S-1:0] num_10s_r;
  logic            busy_r;
  logic            done_r;
`ifdef COUNTDOWN_AUTORELOAD_EN
  logic [W1S-1:0]  preset_1s_r;
  logic [W10S-1:0] preset_10s_r;
`endif

  logic            tick_s;
  logic            en_s;
  logic            is_zero_s;
  logic            last_sec_s;
  logic [W1S-1:0]  dec_1s_s;
  logic [W10S-1:0] dec_10s_s;

  assign en_s       = (state_r == RUN) && START;
  assign is_zero_s  = (num_1s_r == 4'd0) && (num_10s_r == 3'd0);
  assign last_sec_s = (num_1s_r == 4'd1) && (num_10s_r == 3'd0);

  tick_prescaler #(.CLK_FREQ(CLK_FREQ)) u_prescaler (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (en_s),
    .CLR  (LOAD),
    .TICK (tick_s)
  );

  // BCD decrement with borrow; saturates at 00.
  always_comb begin
    dec_1s_s  = num_1s_r;
    dec_10s_s = num_10s_r;
    if (num_1s_r != 4'd0) begin
      dec_1s_s = num_1s_r - 4'd1;
    end else if (num_10s_r != 3'd0) begin
      dec_1s_s  = MAX_1S;
      dec_10s_s = num_10s_r - 3'd1;
    end else begin
      dec_1s_s  = 4'd0;
      dec_10s_s = 3'd0;
    end
  end

  // Control FSM with registered digits, BUSY and DONE; LOAD overrides everything.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r   <= IDLE;
      num_1s_r  <= 4'd0;
      num_10s_r <= 3'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      preset_1s_r  <= 4'd0;
      preset_10s_r <= 3'd0;
`endif
    end else if (LOAD) begin
      state_r   <= IDLE;
      num_1s_r  <= clamp_1s(LOAD_1S);
      num_10s_r <= clamp_10s(LOAD_10S);
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
`ifdef COUNTDOWN_AUTORELOAD_EN
      preset_1s_r  <= clamp_1s(LOAD_1S);
      preset_10s_r <= clamp_10s(LOAD_10S);
`endif
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE, PAUSE: begin
          if (START) begin
            if (is_zero_s) begin
              state_r <= EXPIRED;
              done_r  <= 1'b1;
              busy_r  <= 1'b0;
            end else begin
              state_r <= RUN;
              busy_r  <= 1'b1;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        RUN: begin
          if (!START) begin
            state_r <= PAUSE;
            busy_r  <= 1'b0;
          end else if (tick_s) begin
            if (last_sec_s) begin
              done_r <= 1'b1;
`ifdef COUNTDOWN_AUTORELOAD_EN
              // START is high here, so the timer keeps running on the reloaded count.
              num_1s_r  <= preset_1s_r;
              num_10s_r <= preset_10s_r;
              busy_r    <= 1'b1;
`else
              num_1s_r  <= 4'd0;
              num_10s_r <= 3'd0;
              state_r   <= EXPIRED;
              busy_r    <= 1'b0;
`endif
            end else begin
              num_1s_r  <= dec_1s_s;
              num_10s_r <= dec_10s_s;
            end
          end else begin
            busy_r <= 1'b1;
          end
        end
        EXPIRED: begin
          num_1s_r  <= 4'd0;
          num_10s_r <= 3'd0;
          busy_r    <= 1'b0;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign NUM_1S  = num_1s_r;
  assign NUM_10S = num_10s_r;
  assign BUSY    = busy_r;
  assign DONE    = done_r;

endmodule

// File: tb/tb_countdown_timer.sv
// Self-checking bench for countdown_timer: directed scenarios plus random stimulus
// compared every cycle against an arithmetic model (remaining = loaded - run_cycles / CF).
module tb_countdown_timer;

  localparam int CF = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_1s = 4'd0;
  logic [2:0] load_10s = 3'd0;
  logic       start = 1'b0;
  logic [3:0] num_1s;
  logic [2:0] num_10s;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int m_preset, m_loaded, m_runcyc;
  bit m_running, m_expired, m_done;

  countdown_timer #(.CLK_FREQ(CF)) dut (
    .CLK(clk), .RST(rst), .LOAD(load), .LOAD_1S(load_1s), .LOAD_10S(load_10s),
    .START(start), .NUM_1S(num_1s), .NUM_10S(num_10s), .BUSY(busy), .DONE(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int remaining();
    return m_expired ? 0 : (m_loaded - m_runcyc / CF);
  endfunction

  task automatic model_reset();
    m_preset = 0; m_loaded = 0; m_runcyc = 0;
    m_running = 0; m_expired = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit ld, input int l1, input int l10, input bit st);
    m_done = 0;
    if (ld) begin
      m_preset  = ((l10 > 5) ? 5 : l10) * 10 + ((l1 > 9) ? 9 : l1);
      m_loaded  = m_preset;
      m_runcyc  = 0;
      m_running = 0;
      m_expired = 0;
    end else if (m_expired) begin
      m_running = 0;
    end else if (!m_running) begin
      if (st) begin
        if (remaining() == 0) begin
          m_expired = 1; m_done = 1;
        end else begin
          m_running = 1;
        end
      end
    end else if (!st) begin
      m_running = 0;
    end else begin
      m_runcyc++;
      if (remaining() == 0) begin
        m_done = 1;
`ifdef COUNTDOWN_AUTORELOAD_EN
        m_loaded = m_preset;
        m_runcyc = 0;
`else
        m_running = 0;
        m_expired = 1;
`endif
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".num_1s"}, int'(num_1s), remaining() % 10);
    check({tag, ".num_10s"}, int'(num_10s), remaining() / 10);
    check({tag, ".busy"}, int'(busy), int'(m_running));
    check({tag, ".done"}, int'(done), int'(m_done));
  endtask

  // Apply inputs, take one clock edge, advance model, compare 1 ns after the edge.
  task automatic step(input bit ld, input logic [3:0] l1, input logic [2:0] l10, input bit st,
                      input string tag);
    load = ld; load_1s = l1; load_10s = l10; start = st;
    @(posedge clk);
    model_edge(ld, int'(l1), int'(l10), st);
    #1;
    check_all(tag);
  endtask

  initial begin
    int done_cnt;
    int busy_seen;
    int done_at;
    int guard;
    bit st;
    bit ld;
    logic [3:0] r1;
    logic [2:0] r10;

    // reset held for 10 cycles
    model_reset();
    repeat (10) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b1;

    // load 0:12, hold START: 11 / 10 / 09 after 5 / 10 / 15 run cycles, DONE at 60
    step(1'b1, 4'd2, 3'd1, 1'b0, "s12_load");
    done_cnt = 0;
    for (int i = 0; i < 65; i++) begin
      step(1'b0, 4'd0, 3'd0, 1'b1, "s12_run");
      done_cnt += int'(done);
      if (i == 5)  check("s12_at5", int'(num_10s) * 10 + int'(num_1s), 11);
      if (i == 10) check("s12_at10", int'(num_10s) * 10 + int'(num_1s), 10);
      if (i == 15) check("s12_at15", int'(num_10s) * 10 + int'(num_1s), 9);
      if (i == 60) check("s12_done_at60", int'(done), 1);
    end
`ifndef COUNTDOWN_AUTORELOAD_EN
    check("s12_done_count", done_cnt, 1);
    check("s12_expired_digits", int'(num_10s) * 10 + int'(num_1s), 0);
`endif

    // pause: 7 cycles START high, 20 low, resume; expiry after 15 run cycles total
    step(1'b1, 4'd3, 3'd0, 1'b0, "pause_load");
    for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 3'd0, 1'b1, "pause_run1");
    for (int i = 0; i < 20; i++) step(1'b0, 4'd0, 3'd0, 1'b0, "pause_hold");
    check("pause_held_digit", int'(num_1s), 2);
    done_at = -1;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 4'd0, 3'd0, 1'b1, "pause_run2");
      if (done && done_at < 0) done_at = i;
    end
    check("pause_resume_done_step", done_at, 10);

    // clamp
    step(1'b1, 4'hF, 3'd7, 1'b0, "clamp");
    check("clamp_59", int'(num_10s) * 10 + int'(num_1s), 59);

    // LOAD on a tick cycle wins over the decrement
    step(1'b1, 4'd3, 3'd0, 1'b0, "prio_load");
    step(1'b0, 4'd0, 3'd0, 1'b1, "prio_start");
    guard = 0;
    while ((m_runcyc % CF) != (CF - 1) && guard < 20) begin
      step(1'b0, 4'd0, 3'd0, 1'b1, "prio_run");
      guard++;
    end
    check("prio_reached_tick", int'(guard < 20), 1);
    step(1'b1, 4'd7, 3'd0, 1'b1, "prio_load_on_tick");
    check("prio_digits", int'(num_10s) * 10 + int'(num_1s), 7);
    check("prio_busy", int'(busy), 0);
    step(1'b0, 4'd0, 3'd0, 1'b0, "prio_after");
    check("prio_no_decrement", int'(num_1s), 7);

    // zero preset: single DONE, BUSY never high
    step(1'b1, 4'd0, 3'd0, 1'b0, "zero_load");
    done_cnt = 0; busy_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 4'd0, 3'd0, 1'b1, "zero_run");
      done_cnt += int'(done);
      busy_seen += int'(busy);
    end
    check("zero_done_count", done_cnt, 1);
    check("zero_busy_seen", busy_seen, 0);

    // random stimulus against the model
    for (int i = 0; i < 800; i++) begin
      ld  = ($urandom_range(0, 99) < 3);
      st  = ($urandom_range(0, 9) != 0);
      r1  = 4'($urandom_range(0, 15));
      r10 = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
      step(ld, r1, r10, st, "rand");
    end

    // asynchronous reset mid-run
    step(1'b1, 4'd5, 3'd0, 1'b0, "arst_load");
    for (int i = 0; i < 7; i++) step(1'b0, 4'd0, 3'd0, 1'b1, "arst_run");
    #2 rst = 1'b0;
    model_reset();
    #1;
    check_all("arst_immediate");
    @(negedge clk);
    rst = 1'b1;
    step(1'b0, 4'd0, 3'd0, 1'b0, "arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
